// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line and baud tick in, received byte and strobes out.
interface uart_rx_if #(
   parameter int NB_DATA = 8
);
   logic               i_tick;
   logic               i_rx;
   logic [NB_DATA-1:0] o_data;
   logic               o_rxdone;
   logic               o_frame_err;

   modport master (
      output i_tick,
      output i_rx,
      input  o_data,
      input  o_rxdone,
      input  o_frame_err
   );

   modport slave (
      input  i_tick,
      input  i_rx,
      output o_data,
      output o_rxdone,
      output o_frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: synchronises the line, finds the start bit,
// samples each data bit at mid-bit and strobes out a byte or a framing error.
module uart_rx #(
   parameter int NB_DATA = 8,
   parameter int NB_STOP = 16
) (
   input  logic     clk,
   input  logic     i_reset,
   uart_rx_if.slave bus
);
   localparam int                 NB_BCNT   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
   localparam logic [3:0]         TICK_HALF = 4'(NB_STOP / 2 - 1);
   localparam logic [3:0]         TICK_LAST = 4'(NB_STOP - 1);
   localparam logic [NB_BCNT-1:0] BIT_LAST  = NB_BCNT'(NB_DATA - 1);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      DATA  = 4'b0100,
      STOP  = 4'b1000
   } state_t;

   state_t             r_state;
   logic               r_rx_meta;
   logic               r_rx_s;
   logic               r_rx_p;
   logic [1:0]         r_sync_vld;
   logic               r_armed;
   logic [3:0]         r_tick_cnt;
   logic [NB_BCNT-1:0] r_bit_cnt;
   logic [NB_DATA-1:0] r_shift;
   logic [NB_DATA-1:0] r_data;
   logic               r_rxdone;
   logic               r_frame_err;
   logic               w_fall;

   // A start edge only counts once the line has been seen high; this keeps a
   // line held low across reset release from looking like a start bit.
   assign w_fall = r_armed & r_rx_p & ~r_rx_s;

   assign bus.o_data      = r_data;
   assign bus.o_rxdone    = r_rxdone;
   assign bus.o_frame_err = r_frame_err;

   // Two-flop synchroniser, previous-sample flop and line-seen-high qualifier.
   // r_rx_s only reflects the pin from the third clock after reset, so the
   // qualifier waits for r_sync_vld before trusting it.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         r_rx_meta  <= 1'b1;
         r_rx_s     <= 1'b1;
         r_rx_p     <= 1'b1;
         r_sync_vld <= 2'b00;
         r_armed    <= 1'b0;
      end else begin
         r_rx_meta  <= bus.i_rx;
         r_rx_s     <= r_rx_meta;
         r_rx_p     <= r_rx_s;
         r_sync_vld <= {r_sync_vld[0], 1'b1};
         if (r_sync_vld[1] && r_rx_s) begin
            r_armed <= 1'b1;
         end
      end
   end

   // Receive FSM with registered byte and one-clock strobes.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_rxdone    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rxdone    <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state    <= START;
                  r_tick_cnt <= '0;
               end
            end
            START: begin
               if (bus.i_tick) begin
                  if (r_tick_cnt == TICK_HALF) begin
                     if (!r_rx_s) begin
                        r_state    <= DATA;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (bus.i_tick) begin
                  if (r_tick_cnt == TICK_LAST) begin
                     r_shift    <= {r_rx_s, r_shift[NB_DATA-1:1]};
                     r_tick_cnt <= '0;
                     if (r_bit_cnt == BIT_LAST) begin
                        r_state <= STOP;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
            end
            STOP: begin
               if (bus.i_tick) begin
                  if (r_tick_cnt == TICK_LAST) begin
                     r_state <= IDLE;
                     if (r_rx_s) begin
                        r_data   <= r_shift;
                        r_rxdone <= 1'b1;
                     end else begin
                        r_frame_err <= 1'b1;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives 8N1 frames bit-by-bit and checks every strobe
// and the held byte against a queue of frames the bench itself has sent.
module tb_uart_rx;
   localparam int NB_DATA  = 8;
   localparam int NB_STOP  = 16;
   localparam int TICK_PER = 4;

   typedef struct {
      bit         err;
      logic [7:0] data;
      int         lo;
      int         hi;
   } exp_t;

   logic clk     = 1'b0;
   logic i_reset = 1'b1;
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   cyc     = 0;
   int   tick_phase;
   logic [7:0] model_data = 8'h00;
   exp_t exp_q[$];

   uart_rx_if #(.NB_DATA(NB_DATA)) bus();

   uart_rx #(
      .NB_DATA(NB_DATA),
      .NB_STOP(NB_STOP)
   ) dut (
      .clk     (clk),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Baud tick: one clk wide, every TICK_PER clocks, random starting phase.
   initial begin
      bus.i_tick = 1'b0;
      tick_phase = $urandom_range(0, TICK_PER - 1);
      forever begin
         @(negedge clk);
         tick_phase = tick_phase + 1;
         bus.i_tick = ((tick_phase % TICK_PER) == 0);
      end
   end

   task automatic hold_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input bit v, input int ticks);
      bus.i_rx = v;
      hold_clk(ticks * TICK_PER);
   endtask

   task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, expv);
      end
   endtask

   // One complete frame; the expected outcome is queued at the start of the
   // stop bit with a window around its middle.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok);
      exp_t e;
      drive_bit(1'b0, NB_STOP);
      for (int i = 0; i < NB_DATA; i++) drive_bit(d[i], NB_STOP);
      e.err  = !stop_ok;
      e.data = d;
      e.lo   = cyc + 20;
      e.hi   = cyc + 48;
      exp_q.push_back(e);
      drive_bit(stop_ok, NB_STOP);
   endtask

   task automatic apply_reset(input bit line, input int n);
      bus.i_rx   = line;
      i_reset    = 1'b1;
      model_data = 8'h00;
      exp_q.delete();
      hold_clk(n);
   endtask

   // Compare process: every cycle, #1 after the edge.
   initial begin
      exp_t cur;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (bus.o_rxdone && bus.o_frame_err) begin
            n_cmp++;
            n_err++;
            $display("FAIL both_strobes at cyc %0d: rxdone=1 frame_err=1, required at most one", cyc);
         end
         if (bus.o_rxdone || bus.o_frame_err) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_strobe at cyc %0d: rxdone=%0b frame_err=%0b, none required",
                        cyc, bus.o_rxdone, bus.o_frame_err);
            end else begin
               cur = exp_q.pop_front();
               if (bus.o_frame_err !== cur.err || cyc < cur.lo || cyc > cur.hi) begin
                  n_err++;
                  $display("FAIL strobe at cyc %0d: frame_err=%0b, required frame_err=%0b in cyc %0d..%0d",
                           cyc, bus.o_frame_err, cur.err, cur.lo, cur.hi);
               end
               if (!cur.err) model_data = cur.data;
               $display("rx cyc=%0d data=%h rxdone=%0b frame_err=%0b (sent %h)",
                        cyc, bus.o_data, bus.o_rxdone, bus.o_frame_err, cur.data);
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
            cur = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missed_strobe at cyc %0d: no strobe, required %s for %h by cyc %0d",
                     cyc, cur.err ? "frame_err" : "rxdone", cur.data, cur.hi);
         end
         n_cmp++;
         if (bus.o_data !== model_data) begin
            n_err++;
            $display("FAIL o_data at cyc %0d: got %h, required %h", cyc, bus.o_data, model_data);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Stimulus
   initial begin
      logic [7:0] d;
      bit ok;
      int gap;
      bus.i_rx = 1'b1;
      i_reset  = 1'b1;
      hold_clk(4);
      check_lit("reset_data", 32'(bus.o_data), 32'h0);
      check_lit("reset_rxdone", 32'(bus.o_rxdone), 32'h0);
      check_lit("reset_frame_err", 32'(bus.o_frame_err), 32'h0);
      i_reset = 1'b0;
      hold_clk(12);

      send_frame(8'hA5, 1'b1);
      check_lit("a5_data", 32'(bus.o_data), 32'hA5);

      drive_bit(1'b0, 4);
      drive_bit(1'b1, 16);
      check_lit("glitch_data", 32'(bus.o_data), 32'hA5);

      send_frame(8'h3C, 1'b0);
      drive_bit(1'b1, 4);
      check_lit("ferr_data_kept", 32'(bus.o_data), 32'hA5);

      send_frame(8'h00, 1'b1);
      check_lit("b2b_first", 32'(bus.o_data), 32'h00);
      send_frame(8'hFF, 1'b1);
      check_lit("b2b_second", 32'(bus.o_data), 32'hFF);
      drive_bit(1'b1, 4);

      // 0x5A aborted by reset in the middle of bit 3
      d = 8'h5A;
      drive_bit(1'b0, NB_STOP);
      for (int i = 0; i < 3; i++) drive_bit(d[i], NB_STOP);
      drive_bit(d[3], NB_STOP / 2);
      apply_reset(1'b1, 3);
      check_lit("abort_data", 32'(bus.o_data), 32'h0);
      i_reset = 1'b0;
      drive_bit(1'b1, 4);
      send_frame(8'h81, 1'b1);
      check_lit("after_abort", 32'(bus.o_data), 32'h81);

      // reset released with the line low
      apply_reset(1'b0, 4);
      i_reset = 1'b0;
      drive_bit(1'b0, 20);
      check_lit("low_line_data", 32'(bus.o_data), 32'h0);
      drive_bit(1'b1, 4);
      send_frame(8'h42, 1'b1);
      check_lit("after_low_line", 32'(bus.o_data), 32'h42);
      drive_bit(1'b1, 2);

      // random frames, framing errors, glitches and gaps
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            drive_bit(1'b0, $urandom_range(1, 6));
            drive_bit(1'b1, 8);
         end else begin
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 4) != 0);
            send_frame(d, ok);
            gap = ok ? $urandom_range(0, 3) : $urandom_range(2, 4);
            if (gap > 0) drive_bit(1'b1, gap);
         end
      end

      drive_bit(1'b1, 4);
      hold_clk(100);
      check_lit("pending_frames", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the team's 16x-oversampled UART transmitter. It takes the serial line, synchronises it into the clk domain and detects a start bit. It samples each data bit at mid-bit on the shared baud tick, then presents the received byte with a one-cycle done strobe. Stop-bit violations are flagged as framing errors. It sits between the board RX pin and the interface/command logic.

Parameters:
NB_DATA, 8, data bits per frame (LSB first)
NB_STOP, 16, ticks per bit period (oversampling factor; tick counter is 4 bits, so NB_STOP <= 16 and is even)

Ports:
clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_tick  input  1  baud oversampling tick, one clk wide, NB_STOP ticks per bit
i_rx  input  1  serial line, idle high, asynchronous to clk
o_data  output  NB_DATA  last correctly received byte
o_rxdone  output  1  one-clk pulse when o_data is updated with a valid frame
o_frame_err  output  1  one-clk pulse when the stop bit samples low

Behaviour:
- Reset (async, active-high): state=IDLE, tick counter=0, bit counter=0, shift register=0, o_data=0, o_rxdone=0, o_frame_err=0, both synchroniser flops=1, previous-sample flop=1.
- Input path: i_rx passes through a 2-flop synchroniser (rx_s). A previous-sample flop (rx_p) follows. Falling edge = rx_p==1 && rx_s==0.
- FSM, one-hot, 4 states. All counters advance only on clk cycles with i_tick=1.
- IDLE: on a falling edge (independent of i_tick), go to START and clear the tick counter.
- START: on each tick, count. When count == NB_STOP/2-1, check rx_s:
  - rx_s==0: go to DATA; clear the tick counter and bit counter.
  - rx_s==1: glitch; return to IDLE with no output activity.
- DATA: on each tick, count. When count == NB_STOP-1:
  - Shift rx_s into the shift-register MSB (right shift), so the LSB-first frame lands in natural order.
  - Clear the tick counter.
  - If bit counter == NB_DATA-1, go to STOP; otherwise increment the bit counter.
  - This samples at mid-bit, because START ended at mid-start-bit.
- STOP: on each tick, count. When count == NB_STOP-1, go to IDLE, then:
  - rx_s==1: load o_data from the shift register and pulse o_rxdone high for exactly one clk.
  - rx_s==0: pulse o_frame_err high for one clk; o_data keeps its previous value.
- Strobe timing: registered, so each strobe is high in the clk cycle after the tick that took the stop sample. o_rxdone and o_frame_err are never high together.
- Latency: i_rx edge to the rx_s edge is 2 clk.
- Back-to-back frames: IDLE is entered at mid-stop-bit. The next start edge is accepted as soon as it appears; no extra idle time is required.
- No falling edge exists while the line sits low, so no frame starts until the line has returned high. This covers reset released with the line low, and a line held low after a framing error (break).
- Reset mid-frame aborts immediately. The partial byte is discarded, no strobe is produced, and o_data returns to 0.
- Ticks arriving while in IDLE have no effect.
- An illegal state encoding recovers to IDLE on the next clk.

Test Plan:
- Send 0xA5 at i_tick every 4 clk (8N1, 16 ticks/bit) -> exactly one o_rxdone pulse, after the mid-stop-bit tick; o_data==0xA5; o_frame_err stays 0.
- Drive i_rx low for 4 ticks, then high -> FSM returns to IDLE; no o_rxdone or o_frame_err; o_data unchanged.
- Send 0x3C with the stop bit driven low -> one o_frame_err pulse; o_rxdone stays 0; o_data keeps its prior value (0xA5).
- Send 0x00 then 0xFF back-to-back with a single stop bit each -> two o_rxdone pulses, o_data 0x00 then 0xFF.
- Assert i_reset during bit 3 of 0x5A, release, then send 0x81 -> no strobe for the aborted frame; o_data==0 after reset; then o_data==0x81 with one o_rxdone.
- Release reset with i_rx held low for 20 ticks, then send 0x42 -> nothing is received while the line is low; 0x42 is received correctly once the line returns high and a new start edge arrives.
